bht_update_ctrl: RTL and testbench

- Sits between the EX-stage branch-resolution logic and the branch history table's single update port (update, PC_update, BR).
- Buffers resolved-branch updates in a small FIFO and issues at most one update per cycle.
- Provides a table-clear sequencer for context switch or flush. It walks every table index with saturating not-taken updates until all 2^BITS-saturating counters reach 0.
- The clear uses only the normal update port; the table needs no extra clear port.

---
 rtl/bht_update_ctrl.sv | 129 ++++++++++++
 tb/tb_bht_update_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl
//   Front end for the branch history table's single update port. Resolved
//   branch updates from EX are buffered in a small FIFO and issued one per
//   cycle. A table-clear sweep reuses the same port: it drives not-taken
//   updates to every index, MAX_VAL times over, so that every saturating
//   counter ends at 0.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    resolved-branch handshake (req_pc, req_taken)
//   clear_req              pulse: start or restart a table-clear sweep
//   clear_busy/clear_done  sweep in progress / pulse on last sweep cycle
//   bht_update/bht_pc/bht_br  table update port
//   fifo_count             current FIFO occupancy
module bht_update_ctrl #(
  parameter int unsigned SET_LEN   = 12,
  parameter int unsigned BITS      = 2,
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [31:0]          req_pc,
  input  logic                 req_taken,
  output logic                 req_ready,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 bht_update,
  output logic [31:0]          bht_pc,
  output logic                 bht_br,
  output logic [DEPTH_LOG:0]   fifo_count
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG;
  localparam int unsigned MAX_VAL = (1 << BITS) - 1;
  localparam int unsigned PASS_W  = $clog2(MAX_VAL + 1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t                 state, state_nxt;
  logic [31:0]            pc_mem [DEPTH];
  logic                   tk_mem [DEPTH];
  logic [DEPTH_LOG-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0]     count;
  logic [SET_LEN-1:0]     idx;
  logic [PASS_W-1:0]      pass;
  logic                   empty, full, push, pop, last;

  assign empty      = (count == '0);
  assign full       = (count == (DEPTH_LOG+1)'(DEPTH));
  // Readiness depends only on occupancy; a pop in the same cycle does not
  // free a slot early.
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign fifo_count = count;
  assign clear_busy = (state == CLEAR);
  assign last       = (state == CLEAR) && (idx == '1) &&
                      (pass == PASS_W'(MAX_VAL - 1));

  always_comb begin
    state_nxt  = state;
    bht_update = 1'b0;
    bht_pc     = '0;
    bht_br     = 1'b0;
    pop        = 1'b0;
    clear_done = 1'b0;
    case (state)
      RUN: begin
        if (!empty) begin
          bht_update = 1'b1;
          bht_pc     = pc_mem[rd_ptr];
          bht_br     = tk_mem[rd_ptr];
          pop        = 1'b1;
        end
        if (clear_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        bht_update = 1'b1;
        bht_pc     = {{(32-SET_LEN){1'b0}}, idx};
        // A restart on the final cycle wins over completion.
        if (clear_req) begin
          state_nxt = CLEAR;
        end else if (last) begin
          clear_done = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= req_pc;
      tk_mem[wr_ptr] <= req_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
      pass   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      // Flush drops everything before the clear; a same-cycle push lands at
      // the old write pointer, which becomes the new head.
      if (clear_req) begin
        rd_ptr <= wr_ptr;
        count  <= push ? (DEPTH_LOG+1)'(1) : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + DEPTH_LOG'(1);
        count <= count + (DEPTH_LOG+1)'(push) - (DEPTH_LOG+1)'(pop);
      end
      if (clear_req || last) begin
        idx  <= '0;
        pass <= '0;
      end else if (state == CLEAR) begin
        idx <= idx + SET_LEN'(1);
        if (idx == '1) pass <= pass + PASS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb_bht_update_ctrl
//   Directed bench for bht_update_ctrl with a small table (SET_LEN=3, BITS=2,
//   DEPTH_LOG=2). A queue-based model predicts every output each cycle; a
//   few literal checks pin the scenarios, and a tiny saturating-counter
//   table receives the update port to confirm the clear sweep.
module tb_bht_update_ctrl;

  localparam int unsigned SL = 3;
  localparam int unsigned BT = 2;
  localparam int unsigned DL = 2;
  localparam int NIDX  = 1 << SL;
  localparam int NPASS = (1 << BT) - 1;
  localparam int SWEEP = NIDX * NPASS;
  localparam int QMAX  = 1 << DL;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_taken, clear_req;
  logic [31:0] req_pc;
  logic        req_ready, clear_busy, clear_done, bht_update, bht_br;
  logic [31:0] bht_pc;
  logic [DL:0] fifo_count;

  int n_assert = 0;
  int n_fail   = 0;

  bht_update_ctrl #(.SET_LEN(SL), .BITS(BT), .DEPTH_LOG(DL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
    .req_taken(req_taken), .req_ready(req_ready), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done), .bht_update(bht_update),
    .bht_pc(bht_pc), .bht_br(bht_br), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: queue of pending updates plus a sweep-cycle counter.
  logic [32:0] q[$];
  bit          in_clr = 0;
  int          k      = 0;
  bit          mvalid = 0;
  bit          mpush;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      in_clr = 0;
      k      = 0;
      mvalid = 1;
    end else begin
      mpush = req_valid && (q.size() < QMAX);
      if (clear_req) begin
        q.delete();
        in_clr = 1;
        k      = 0;
      end else if (in_clr) begin
        if (k == SWEEP - 1) in_clr = 0;
        else k++;
      end else if (q.size() > 0) begin
        void'(q.pop_front());
      end
      if (mpush) q.push_back({req_pc, req_taken});
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic [31:0] epc;
      logic        ebr;
      epc = 0;
      ebr = 0;
      if (in_clr) epc = k % NIDX;
      else if (q.size() > 0) begin
        epc = q[0][32:1];
        ebr = q[0][0];
      end
      chk("m_ready",  req_ready,  q.size() < QMAX);
      chk("m_count",  fifo_count, q.size());
      chk("m_busy",   clear_busy, in_clr);
      chk("m_done",   clear_done, in_clr && (k == SWEEP - 1) && !clear_req);
      chk("m_update", bht_update, in_clr || (q.size() > 0));
      chk("m_pc",     bht_pc,     epc);
      chk("m_br",     bht_br,     ebr);
    end
  end

  // Small table driven by the update port.
  int tbl [NIDX];
  always @(posedge clk) begin
    if (rst_n && bht_update) begin
      if (bht_br) begin
        if (tbl[bht_pc[SL-1:0]] < NPASS) tbl[bht_pc[SL-1:0]]++;
      end else begin
        if (tbl[bht_pc[SL-1:0]] > 0) tbl[bht_pc[SL-1:0]]--;
      end
    end
  end

  initial begin
    int busy_cnt, done_cnt;
    bit restarted;
    rst_n = 0; req_valid = 0; req_pc = '0; req_taken = 0; clear_req = 0;
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_update", bht_update, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_pc", bht_pc, 0);
    rst_n = 1;
    step();

    // Single update latency
    req_valid = 1; req_pc = 32'h100; req_taken = 1;
    step();
    req_valid = 0;
    chk("t1_update", bht_update, 1);
    chk("t1_pc", bht_pc, 32'h100);
    chk("t1_br", bht_br, 1);
    step();
    chk("t1_idle", bht_update, 0);
    chk("t1_count", fifo_count, 0);

    // FIFO fill during CLEAR, then in-order drain
    clear_req = 1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_pc = 32'h200 + i; req_taken = i[0];
      step();
      clear_req = 0;
    end
    chk("t2_full_count", fifo_count, 4);
    chk("t2_full_ready", req_ready, 0);
    for (int n = 0; n < 60 && !clear_done; n++) step();
    chk("t2_done_seen", clear_done, 1);
    step();
    chk("t2_ready_not_relieved", req_ready, 0);
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_update", bht_update, 1);
      chk("t2_drain_pc", bht_pc, 32'h200 + i);
      step();
    end
    chk("t2_drained", bht_update, 0);

    // Full sweep against a preloaded table
    for (int j = 0; j < NIDX; j++) tbl[j] = NPASS;
    clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 0; i < SWEEP; i++) begin
      chk("t3_busy", clear_busy, 1);
      chk("t3_pc", bht_pc, i % NIDX);
      chk("t3_br", bht_br, 0);
      chk("t3_done", clear_done, (i == SWEEP - 1));
      step();
    end
    chk("t3_end_busy", clear_busy, 0);
    for (int j = 0; j < NIDX; j++) chk("t3_table", tbl[j], 0);

    // Restart at sweep cycle 10
    clear_req = 1;
    step();
    clear_req = 0;
    busy_cnt = 0; done_cnt = 0; restarted = 0;
    for (int n = 0; n < 80; n++) begin
      if (!clear_busy) break;
      busy_cnt++;
      if (clear_done) done_cnt++;
      if (busy_cnt == 10 && !restarted) begin
        restarted = 1;
        clear_req = 1;
        step();
        clear_req = 0;
        chk("t4_restart_pc", bht_pc, 0);
      end else begin
        step();
      end
    end
    chk("t4_busy_cycles", busy_cnt, 34);
    chk("t4_done_count", done_cnt, 1);

    // Clear concurrent with a push: only that push survives
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_pc = 32'h10 + 4 * i; req_taken = 1;
      step();
    end
    clear_req = 1; req_valid = 1; req_pc = 32'h44; req_taken = 0;
    step();
    clear_req = 0; req_valid = 0;
    chk("t5_count", fifo_count, 1);
    for (int n = 0; n < 60 && !clear_done; n++) step();
    chk("t5_done_seen", clear_done, 1);
    step();
    chk("t5_update", bht_update, 1);
    chk("t5_pc", bht_pc, 32'h44);
    chk("t5_br", bht_br, 0);
    step();
    chk("t5_empty", fifo_count, 0);

    // Reset mid-sweep
    clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("t6_busy", clear_busy, 0);
    chk("t6_update", bht_update, 0);
    chk("t6_count", fifo_count, 0);
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      if (clear_done) done_cnt++;
      step();
    end
    chk("t6_no_done", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
